// File: rtl/modexp_mont_param.sv
// ============================================================================
//  Module      : modexp_mont_param
//  Description : Radix-2 Montgomery modular exponentiation, cypher = msg^exp mod N,
//                with internal R^2 generation, operand validation and LZ-skip option.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modexp_mont_param #(
    parameter int WIDTH     = 4096,
    parameter int EXP_WIDTH = WIDTH,
    parameter bit SKIP_LZ   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     message,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     cypher
);

    localparam int TW  = WIDTH + 2;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int IW  = $clog2(WIDTH);
    localparam int RW  = $clog2(2 * WIDTH);
    localparam int BW  = $clog2(EXP_WIDTH) + 1;
    localparam int BIW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CHECK = 4'd1;
    localparam logic [3:0] S_R2    = 4'd2;
    localparam logic [3:0] S_TOM   = 4'd3;
    localparam logic [3:0] S_TOA   = 4'd4;
    localparam logic [3:0] S_SCAN  = 4'd5;
    localparam logic [3:0] S_SQR   = 4'd6;
    localparam logic [3:0] S_MUL   = 4'd7;
    localparam logic [3:0] S_FROM  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    logic [3:0]           state_q,  state_d;
    logic [WIDTH-1:0]     msg_q,    msg_d;
    logic [EXP_WIDTH-1:0] exp_q,    exp_d;
    logic [WIDTH-1:0]     mod_q,    mod_d;
    logic [WIDTH-1:0]     r2_q,     r2_d;
    logic [WIDTH-1:0]     mbar_q,   mbar_d;
    logic [WIDTH-1:0]     a_q,      a_d;
    logic [TW-1:0]        t_q,      t_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [RW-1:0]        r2cnt_q,  r2cnt_d;
    logic [BW-1:0]        bit_q,    bit_d;
    logic                 err_q,    err_d;
    logic                 done_q,   done_d;
    logic                 error_q,  error_d;
    logic [WIDTH-1:0]     cypher_q, cypher_d;

    logic [WIDTH-1:0] w_mm_a;
    logic [WIDTH-1:0] w_mm_b;
    logic             w_mm_bit;
    logic             w_mm_last;
    logic [TW-1:0]    w_t_add;
    logic [TW-1:0]    w_t_odd;
    logic [TW-1:0]    w_t_next;
    logic [WIDTH-1:0] w_mm_res;
    logic [WIDTH:0]   w_dbl;
    logic [WIDTH-1:0] w_r2_next;
    logic             w_ebit;
    logic             w_bit_zero;

    // One shared Montgomery datapath; the state selects which operands feed it.
    always_comb begin
        w_mm_a = a_q;
        w_mm_b = a_q;
        case (state_q)
            S_TOM:   begin w_mm_a = msg_q; w_mm_b = r2_q;   end
            S_TOA:   begin w_mm_a = r2_q;  w_mm_b = C_ONE;  end
            S_MUL:   begin w_mm_a = a_q;   w_mm_b = mbar_q; end
            S_FROM:  begin w_mm_a = a_q;   w_mm_b = C_ONE;  end
            default: begin w_mm_a = a_q;   w_mm_b = a_q;    end
        endcase
    end

    assign w_mm_bit  = w_mm_a[cnt_q[IW-1:0]];
    assign w_mm_last = (cnt_q == CW'(WIDTH));
    assign w_t_add   = t_q + (w_mm_bit ? {2'b00, w_mm_b} : TW'(0));
    assign w_t_odd   = w_t_add + (w_t_add[0] ? {2'b00, mod_q} : TW'(0));
    assign w_t_next  = TW'(w_t_odd >> 1);
    assign w_mm_res  = WIDTH'((t_q >= {2'b00, mod_q}) ? (t_q - {2'b00, mod_q}) : t_q);

    assign w_dbl     = {r2_q, 1'b0};
    assign w_r2_next = WIDTH'((w_dbl >= {1'b0, mod_q}) ? (w_dbl - {1'b0, mod_q}) : w_dbl);

    assign w_ebit     = exp_q[bit_q[BIW-1:0]];
    assign w_bit_zero = (bit_q == '0);

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        r2_d     = r2_q;
        mbar_d   = mbar_q;
        a_d      = a_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        r2cnt_d  = r2cnt_q;
        bit_d    = bit_q;
        err_d    = err_q;
        done_d   = 1'b0;
        error_d  = error_q;
        cypher_d = cypher_q;

        if ((state_q == S_TOM) || (state_q == S_TOA) || (state_q == S_SQR) ||
            (state_q == S_MUL) || (state_q == S_FROM)) begin
            if (!w_mm_last) begin
                t_d   = w_t_next;
                cnt_d = cnt_q + CW'(1);
            end else begin
                t_d   = '0;
                cnt_d = '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d   = message;
                    exp_d   = exponent;
                    mod_d   = modulus;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                t_d   = '0;
                cnt_d = '0;
                if (!mod_q[0] || (msg_q >= mod_q)) begin
                    err_d   = 1'b1;
                    a_d     = '0;
                    state_d = S_DONE;
                end else begin
                    r2_d    = C_ONE;
                    r2cnt_d = '0;
                    state_d = S_R2;
                end
            end
            S_R2: begin
                r2_d    = w_r2_next;
                r2cnt_d = r2cnt_q + RW'(1);
                if (r2cnt_q == RW'(2 * WIDTH - 1)) begin
                    state_d = S_TOM;
                end
            end
            S_TOM: begin
                if (w_mm_last) begin
                    mbar_d  = w_mm_res;
                    state_d = S_TOA;
                end
            end
            S_TOA: begin
                if (w_mm_last) begin
                    a_d     = w_mm_res;
                    bit_d   = BW'(EXP_WIDTH - 1);
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!SKIP_LZ || w_ebit) begin
                    state_d = S_SQR;
                end else if (w_bit_zero) begin
                    state_d = S_FROM;
                end else begin
                    bit_d = bit_q - BW'(1);
                end
            end
            S_SQR: begin
                if (w_mm_last) begin
                    a_d = w_mm_res;
                    if (!SKIP_LZ || w_ebit) begin
                        state_d = S_MUL;
                    end else if (w_bit_zero) begin
                        state_d = S_FROM;
                    end else begin
                        bit_d   = bit_q - BW'(1);
                        state_d = S_SQR;
                    end
                end
            end
            S_MUL: begin
                // In constant-time mode a 0 bit still multiplies but discards the product.
                if (w_mm_last) begin
                    if (w_ebit) begin
                        a_d = w_mm_res;
                    end
                    if (w_bit_zero) begin
                        state_d = S_FROM;
                    end else begin
                        bit_d   = bit_q - BW'(1);
                        state_d = S_SQR;
                    end
                end
            end
            S_FROM: begin
                if (w_mm_last) begin
                    a_d     = w_mm_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                error_d  = err_q;
                cypher_d = err_q ? '0 : a_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            msg_q    <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            r2_q     <= '0;
            mbar_q   <= '0;
            a_q      <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            r2cnt_q  <= '0;
            bit_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            cypher_q <= '0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            r2_q     <= r2_d;
            mbar_q   <= mbar_d;
            a_q      <= a_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            r2cnt_q  <= r2cnt_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
            done_q   <= done_d;
            error_q  <= error_d;
            cypher_q <= cypher_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign error  = error_q;
    assign cypher = cypher_q;

endmodule

`default_nettype wire

// File: tb/tb_modexp_mont_param.sv
// ============================================================================
//  Module      : tb_modexp_mont_param
//  Description : Directed bench for modexp_mont_param (LZ-skip and constant-time builds).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modexp_mont_param;

    localparam int W  = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start [2];
    logic [W-1:0]  msg   [2];
    logic [EW-1:0] expo  [2];
    logic [W-1:0]  modv  [2];
    logic          busy  [2];
    logic          done  [2];
    logic          error [2];
    logic [W-1:0]  cy    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    modexp_mont_param #(.WIDTH(W), .EXP_WIDTH(EW), .SKIP_LZ(1'b1)) u_lz (
        .clk(clk), .reset(reset), .start(start[0]), .message(msg[0]),
        .exponent(expo[0]), .modulus(modv[0]), .busy(busy[0]), .done(done[0]),
        .error(error[0]), .cypher(cy[0])
    );

    modexp_mont_param #(.WIDTH(W), .EXP_WIDTH(EW), .SKIP_LZ(1'b0)) u_ct (
        .clk(clk), .reset(reset), .start(start[1]), .message(msg[1]),
        .exponent(expo[1]), .modulus(modv[1]), .busy(busy[1]), .done(done[1]),
        .error(error[1]), .cypher(cy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain modular arithmetic and cycle accounting from the operation rules.
    function automatic int ref_modexp(int m, int e, int n);
        longint r;
        if (n == 1) return 0;
        r = 1;
        for (int i = EW - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (((e >> i) & 1) == 1) r = (r * m) % n;
        end
        return int'(r);
    endfunction

    function automatic bit ref_err(int m, int n);
        return ((n % 2) == 0) || (m >= n);
    endfunction

    function automatic int ref_lat(int m, int e, int n, bit skip);
        int mm, msb, ones, scan, mms;
        mm = W + 1;
        msb = -1;
        ones = 0;
        if (ref_err(m, n)) return 2;
        for (int i = 0; i < EW; i++) begin
            if (((e >> i) & 1) == 1) begin
                ones++;
                msb = i;
            end
        end
        if (!skip) begin
            scan = 1;
            mms  = 2 * EW;
        end else if (e == 0) begin
            scan = EW;
            mms  = 0;
        end else begin
            scan = EW - msb;
            mms  = (msb + 1) + ones;
        end
        return 1 + 2 * W + 2 * mm + scan + mms * mm + mm + 1;
    endfunction

    task automatic run_op(input int d, input int m, input int e, input int n, input bit hold);
        int  lat, ncyc, rcy;
        bit  rerr, seen, busy_ok;
        lat  = ref_lat(m, e, n, d == 0);
        rerr = ref_err(m, n);
        rcy  = rerr ? 0 : ref_modexp(m, e, n);
        msg[d]   = W'(m);
        expo[d]  = EW'(e);
        modv[d]  = W'(n);
        start[d] = 1'b1;
        step();
        if (!hold) start[d] = 1'b0;
        check("busy_after_accept", 32'(busy[d]), 32'd1);
        msg[d]  = ~W'(m);
        expo[d] = ~EW'(e);
        ncyc    = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && ncyc < lat + 8) begin
            step();
            ncyc++;
            if (done[d]) seen = 1'b1;
            else if (!busy[d]) busy_ok = 1'b0;
        end
        check("busy_held", 32'(busy_ok), 32'd1);
        check("done_seen", 32'(seen), 32'd1);
        check("latency", ncyc, lat);
        check("cypher", 32'(cy[d]), rcy);
        check("error", 32'(error[d]), 32'(rerr));
        check("busy_at_done", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit  done_seen;
        bit  busy_seen;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            msg[d]   = '0;
            expo[d]  = '0;
            modv[d]  = '0;
        end
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_done", 32'(done[d]), 32'd0);
            check("rst_error", 32'(error[d]), 32'd0);
            check("rst_cypher", 32'(cy[d]), 32'd0);
        end
        reset = 1'b0;
        step();

        check("pin_modexp", ref_modexp(8, 13, 77), 50);
        check("pin_roundtrip", ref_modexp(50, 37, 77), 8);
        check("pin_lat_lz", ref_lat(8, 13, 77, 1'b1), 113);
        check("pin_lat_ct13", ref_lat(8, 13, 77, 1'b0), 190);
        check("pin_lat_ct1", ref_lat(8, 1, 77, 1'b0), 190);
        check("pin_lat_err", ref_lat(8, 13, 76, 1'b1), 2);

        // Encrypt then decrypt back-to-back with start held high.
        run_op(0, 8, 13, 77, 1'b1);
        run_op(0, 50, 37, 77, 1'b0);
        step();
        check("done_one_cycle", 32'(done[0]), 32'd0);
        check("cypher_held", 32'(cy[0]), 32'd8);

        run_op(0, 8, 13, 76, 1'b0);
        run_op(0, 80, 13, 77, 1'b0);
        run_op(0, 5, 3, 0, 1'b0);
        run_op(0, 8, 0, 77, 1'b0);
        run_op(0, 0, 13, 1, 1'b0);
        run_op(0, 76, 255, 77, 1'b0);
        run_op(0, 3, 5, 7, 1'b0);

        run_op(1, 8, 13, 77, 1'b0);
        run_op(1, 8, 1, 77, 1'b0);
        run_op(1, 50, 37, 77, 1'b0);

        // Abort an operation in the middle of its first squaring.
        msg[0]   = 8'd8;
        expo[0]  = 8'd13;
        modv[0]  = 8'd77;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (45) step();
        check("busy_mid_sqr", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_cypher", 32'(cy[0]), 32'd0);
        step();
        reset = 1'b0;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (150) begin
            step();
            if (done[0]) done_seen = 1'b1;
            if (busy[0]) busy_seen = 1'b1;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_stays_idle", 32'(busy_seen), 32'd0);
        run_op(0, 8, 13, 77, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
